music_output_composition: RTL and testbench

MUSIC_OUTPUT_COMPOSITION -- requirements
Module: music_output_composition

---
 rtl/music_output_composition.sv | 161 ++++++++++++++++
 tb/tb_music_output_composition.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_output_composition.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : music_output_composition
// Description : Plays fragA then fragB as a note stream; optional inter-note
//               gap under MUSIC_COMPOSE_TEMPO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module music_output_composition #(
  parameter int NOTE_W     = 8,
  parameter int FRAG_NOTES = 150
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NOTE_W*FRAG_NOTES-1:0] fragA,
  input  logic [NOTE_W*FRAG_NOTES-1:0] fragB,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   tempo,
  output logic [NOTE_W-1:0]            note_out,
  output logic                         note_valid,
  input  logic                         note_ready,
  output logic                         note_last,
  output logic                         note_frag,
  output logic [15:0]                  song_count
);

  localparam int FW    = NOTE_W * FRAG_NOTES;
  localparam int IDX_W = (FRAG_NOTES > 1) ? $clog2(FRAG_NOTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAG_NOTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY_A = 2'd1,
    PLAY_B = 2'd2,
    GAP    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [FW-1:0]         fraga_q, fraga_d;
  logic [FW-1:0]         fragb_q, fragb_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frag_q, frag_d;
  logic [7:0]            gap_q, gap_d;
  logic [15:0]           count_q, count_d;

  logic                  w_playing;
  logic                  w_last_idx;
  logic                  w_xfer;
  logic [FW-1:0]         w_sel;
  logic [FRAG_NOTES-1:0][NOTE_W-1:0] w_notes;

`ifdef MUSIC_COMPOSE_TEMPO_EN
  logic [7:0]            tempo_q, tempo_d;
`else
  logic                  unused_tempo;
  assign unused_tempo = ^tempo;
`endif

  assign w_playing  = (state_q == PLAY_A) || (state_q == PLAY_B);
  assign w_last_idx = (idx_q == LAST_IDX);
  assign w_sel      = frag_q ? fragb_q : fraga_q;
  assign w_notes    = w_sel;
  assign w_xfer     = w_playing && note_ready;

  assign in_ready   = (state_q == IDLE);
  assign note_valid = w_playing;
  assign note_out   = w_playing ? w_notes[idx_q] : '0;
  assign note_last  = w_playing && frag_q && w_last_idx;
  assign note_frag  = frag_q;
  assign song_count = count_q;

  always_comb begin
    state_d = state_q;
    fraga_d = fraga_q;
    fragb_d = fragb_q;
    idx_d   = idx_q;
    frag_d  = frag_q;
    gap_d   = gap_q;
    count_d = count_q;
`ifdef MUSIC_COMPOSE_TEMPO_EN
    tempo_d = tempo_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fraga_d = fragA;
          fragb_d = fragB;
`ifdef MUSIC_COMPOSE_TEMPO_EN
          tempo_d = tempo;
`endif
          idx_d   = '0;
          frag_d  = 1'b0;
          state_d = PLAY_A;
        end
      end
      PLAY_A, PLAY_B: begin
        if (w_xfer) begin
          if (note_last) begin
            count_d = count_q + 16'd1;
            idx_d   = '0;
            frag_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // Crossing the fragment boundary restarts the index at note 0 of fragB.
            if (w_last_idx) begin
              idx_d  = '0;
              frag_d = 1'b1;
            end else begin
              idx_d  = idx_q + IDX_W'(1);
            end
            state_d = (frag_q || w_last_idx) ? PLAY_B : PLAY_A;
`ifdef MUSIC_COMPOSE_TEMPO_EN
            if (tempo_q != 8'd0) begin
              gap_d   = tempo_q;
              state_d = GAP;
            end
`endif
          end
        end
      end
      GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = frag_q ? PLAY_B : PLAY_A;
        end else begin
          gap_d   = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fraga_q <= '0;
      fragb_q <= '0;
      idx_q   <= '0;
      frag_q  <= 1'b0;
      gap_q   <= 8'd0;
      count_q <= 16'd0;
`ifdef MUSIC_COMPOSE_TEMPO_EN
      tempo_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      fraga_q <= fraga_d;
      fragb_q <= fragb_d;
      idx_q   <= idx_d;
      frag_q  <= frag_d;
      gap_q   <= gap_d;
      count_q <= count_d;
`ifdef MUSIC_COMPOSE_TEMPO_EN
      tempo_q <= tempo_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_music_output_composition.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_music_output_composition
// Description : Randomized bench with a song-level queue model of the player.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_music_output_composition;

  localparam int NW   = 8;
  localparam int FN   = 150;
  localparam int FW   = NW * FN;
  localparam int SONG = 2 * FN;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [FW-1:0] fragA = '0;
  logic [FW-1:0] fragB = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    tempo = 8'd0;
  logic [NW-1:0] note_out;
  logic          note_valid;
  logic          note_ready = 1'b0;
  logic          note_last;
  logic          note_frag;
  logic [15:0]   song_count;

  music_output_composition #(.NOTE_W(NW), .FRAG_NOTES(FN)) dut (
    .clk        (clk),
    .reset      (reset),
    .fragA      (fragA),
    .fragB      (fragB),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tempo      (tempo),
    .note_out   (note_out),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .note_last  (note_last),
    .note_frag  (note_frag),
    .song_count (song_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] note;
    logic       last;
    logic       frag;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  bit          known = 0;
  bit          just_reset = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_out = '0;
  int          gap_left = 0;
  int          tempo_reg = 0;
  logic [15:0] model_count = '0;
  int          cyc_cnt = 0;
  int          accept_cyc = 0;
  int          last_xfer_cyc = 0;
  int          song_cycles = 0;
  int          xfer_idx = 0;
  int          first_b_idx = -1;
  logic [7:0]  last_note_val = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_song();
    exp_t e;
    for (int k = 0; k < SONG; k++) begin
      e.note = (k < FN) ? fragA[k*NW +: NW] : fragB[(k-FN)*NW +: NW];
      e.last = (k == SONG - 1);
      e.frag = (k >= FN);
      q.push_back(e);
    end
  endtask

  // Checks DUT outputs each falling edge, then advances the model to the next rising edge.
  task automatic monitor();
    bit   ev;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_cnt++;
      ev = (q.size() > 0) && (gap_left == 0);
      if (known) begin
        if (just_reset) begin
          check("rst_note_out", note_out, 0);
          check("rst_note_last", note_last, 0);
          check("rst_note_frag", note_frag, 0);
        end
        check("in_ready", in_ready, (q.size() == 0));
        check("note_valid", note_valid, ev);
        if (ev) begin
          check("note_out", note_out, q[0].note);
          check("note_last", note_last, q[0].last);
          check("note_frag", note_frag, q[0].frag);
        end
        if (prev_stall) check("stall_stable", note_out, prev_out);
        check("song_count", song_count, model_count);
      end
      if (reset) begin
        q.delete();
        gap_left    = 0;
        model_count = '0;
        known       = 1;
        just_reset  = 1;
        prev_stall  = 0;
        xfer_idx    = 0;
      end else if (known) begin
        just_reset = 0;
        prev_stall = ev && !note_ready;
        if (ev) prev_out = q[0].note;
        if (q.size() == 0) begin
          if (in_valid) begin
            push_song();
            tempo_reg   = tempo;
            accept_cyc  = cyc_cnt;
            xfer_idx    = 0;
            first_b_idx = -1;
          end
        end else if (gap_left > 0) begin
          gap_left--;
        end else if (note_ready) begin
          e = q.pop_front();
          if (e.frag && first_b_idx < 0) first_b_idx = xfer_idx;
          xfer_idx++;
          last_note_val = e.note;
          if (e.last) begin
            model_count   = model_count + 16'd1;
            last_xfer_cyc = cyc_cnt;
            song_cycles   = cyc_cnt - accept_cyc;
          end else begin
`ifdef MUSIC_COMPOSE_TEMPO_EN
            gap_left = tempo_reg;
`endif
          end
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < FN; k++) begin
      fragA[k*NW +: NW] = 8'(k);
      fragB[k*NW +: NW] = 8'((FN + k) % 256);
    end
  endtask

  task automatic load_rand();
    for (int k = 0; k < FN; k++) begin
      fragA[k*NW +: NW] = 8'($urandom);
      fragB[k*NW +: NW] = 8'($urandom);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!in_ready && n < budget) begin
      cyc();
      n++;
    end
    check(name, in_ready, 1);
  endtask

  task automatic stimulus();
    int n;
    int rst_at;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Full-rate song with ramp data
    load_ramp();
    tempo = 8'd0;
    note_ready = 1'b1;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    wait_idle(1000, "t1_timeout");
    cyc();
    check("t1_song_cycles", song_cycles, 300);
    check("t1_first_fragB_note", first_b_idx, 150);
    check("t1_last_note", last_note_val, 43);
    check("t1_song_count", song_count, 1);

    // note_ready toggled every cycle, stalled on the first valid cycle
    note_ready = 1'b1;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!in_ready && n < 2000) begin
      note_ready = ~note_ready;
      cyc();
      n++;
    end
    check("t2_timeout", in_ready, 1);
    cyc();
    check("t2_song_cycles", song_cycles, 600);
    check("t2_song_count", song_count, 2);

    // in_valid held through playback with changed data; next pair taken right after note_last
    note_ready = 1'b1;
    in_valid = 1'b1;
    cyc();
    load_rand();
    wait_idle(1000, "t3_timeout");
    cyc();
    in_valid = 1'b0;
    check("t3_back_to_back_accept", accept_cyc - last_xfer_cyc, 1);
    wait_idle(1000, "t3b_timeout");
    cyc();
    check("t3_song_count", song_count, 4);

    // Reset coincident with the transfer of note 100
    load_ramp();
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    n = 0;
    while (!(note_valid && note_out == 8'd100) && n < 500) begin
      cyc();
      n++;
    end
    check("t4_reach_note100", note_out, 100);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t4_valid_after_rst", note_valid, 0);
    check("t4_ready_after_rst", in_ready, 1);
    check("t4_count_after_rst", song_count, 0);
    repeat (5) cyc();

`ifdef MUSIC_COMPOSE_TEMPO_EN
    tempo = 8'd3;
    note_ready = 1'b1;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    tempo = 8'd0;
    wait_idle(3000, "t5_timeout");
    cyc();
    check("t5_tempo_song_cycles", song_cycles, 1197);
    check("t5_song_count", song_count, 1);
`endif

    // Randomized songs: random data, tempo, backpressure, stray in_valid, one mid-song reset
    for (int s = 0; s < 6; s++) begin
      load_rand();
      tempo = 8'($urandom_range(0, 3));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) cyc();
      in_valid = 1'b1;
      cyc();
      rst_at = $urandom_range(50, 400);
      n = 0;
      while (!in_ready && n < 6000) begin
        note_ready = ($urandom_range(0, 3) != 0);
        in_valid   = 1'($urandom_range(0, 1));
        tempo      = 8'($urandom_range(0, 3));
        reset      = (s == 3) && (n == rst_at);
        cyc();
        n++;
      end
      reset = 1'b0;
      in_valid = 1'b0;
      check("rand_timeout", in_ready, 1);
      cyc();
    end
    repeat (3) cyc();
  endtask

  initial begin
    fork
      monitor();
      begin
        stimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
`default_nettype wire
